pw_checking: RTL and testbench

// - Password stage directly downstream of the user-ID checker. Once the ID stage raises matchID, collects a
//   4-digit (16-bit) password from the toggle switches and compares it against the password ROM entry for intID.
// - Asserts matchPW to the game controller on success. Counts failed attempts and gives up after MAX_ATTEMPTS.
// - All state is cleared on log_out.

---
 rtl/pw_pkg.sv | 22 ++
 rtl/pw_lockout_timer.sv | 38 +++
 rtl/pw_checking.sv | 128 ++++++++++++
 tb/tb_pw_checking.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pw_pkg.sv
// Shared definitions for the password-check stage: widths, erased-slot marker, FSM state encoding.
package pw_pkg;
  localparam int DIGIT_W    = 4;
  localparam int PW_W       = 16;
  localparam int ROM_ADDR_W = 5;
  localparam logic [PW_W-1:0] PW_ERASED = 16'hFFFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DIG1,
    S_DIG2,
    S_DIG3,
    S_DIG4,
    S_ROM_ADDR,
    S_ROM_WAIT,
    S_ROM_CATCH,
    S_COMPARE,
    S_GRANTED,
    S_FAIL,
    S_LOCKOUT
  } pw_state_t;
endpackage

// File: rtl/pw_lockout_timer.sv
// Lockout hold timer: start loads the down-counter, locked stays high for LOCKOUT_CYCLES cycles.
// Only built when PW_LOCKOUT_EN is defined.
`ifdef PW_LOCKOUT_EN
module pw_lockout_timer #(
  parameter int LOCKOUT_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_clear,
  output logic o_locked,
  output logic o_done
);
  localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_locked;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_locked <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= CNT_W'(LOCKOUT_CYCLES - 1);
      r_locked <= 1'b1;
    end else if (r_locked) begin
      if (r_cnt == '0) r_locked <= 1'b0;
      else             r_cnt    <= r_cnt - 1'b1;
    end
  end

  assign o_locked = r_locked;
  assign o_done   = r_locked && (r_cnt == '0);
endmodule
`endif

// File: rtl/pw_checking.sv
// Password stage behind the user-ID checker: collects 4 digits, compares with the ROM entry for intID.
// Optional timed lockout release via PW_LOCKOUT_EN; otherwise lockout holds until log_out/matchID drop.
module pw_checking
  import pw_pkg::*;
#(
  parameter int MAX_ATTEMPTS = 3,
  parameter int ROM_WAIT     = 2
`ifdef PW_LOCKOUT_EN
  ,parameter int LOCKOUT_CYCLES = 50_000_000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGIT_W-1:0]    pwdigit,
  input  logic                  pwenter,
  input  logic                  log_out,
  input  logic                  matchID,
  input  logic                  isGuest,
  input  logic [2:0]            intID,
  input  logic [PW_W-1:0]       q_PW_ROM,
  output logic [ROM_ADDR_W-1:0] addr_PW_ROM,
  output logic                  matchPW,
  output logic                  pwFail,
  output logic                  lockedOut,
  output logic [3:0]            o_dbg_state,
  output logic [2:0]            o_dbg_attempt
);
  localparam int              WAIT_W    = (ROM_WAIT > 1) ? $clog2(ROM_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_WAIT - 1);
  localparam logic [2:0]      ATT_LAST  = 3'(MAX_ATTEMPTS - 1);

  pw_state_t             r_state, w_next;
  logic [PW_W-1:0]       r_pw, r_data;
  logic [2:0]            r_attempt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [ROM_ADDR_W-1:0] r_addr;
  logic                  w_take;

  // pwenter is a one-cycle strobe; it is only honoured in a digit state and never alongside log_out.
  assign w_take = pwenter && !log_out;

`ifdef PW_LOCKOUT_EN
  logic w_lock_level, w_lock_done;

  pw_lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_lockout_timer (
    .clk      (clk),
    .rst      (rst),
    .i_start  ((r_state == S_FAIL) && (w_next == S_LOCKOUT)),
    .i_clear  (w_next == S_IDLE),
    .o_locked (w_lock_level),
    .o_done   (w_lock_done)
  );
  assign lockedOut = w_lock_level;
`else
  assign lockedOut = (r_state == S_LOCKOUT);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (matchID) w_next = S_DIG1;
      S_DIG1:      if (w_take) w_next = S_DIG2;
      S_DIG2:      if (w_take) w_next = S_DIG3;
      S_DIG3:      if (w_take) w_next = S_DIG4;
      S_DIG4:      if (w_take) w_next = S_ROM_ADDR;
      S_ROM_ADDR:  w_next = S_ROM_WAIT;
      S_ROM_WAIT:  if (r_wait_cnt == WAIT_LAST) w_next = S_ROM_CATCH;
      S_ROM_CATCH: w_next = S_COMPARE;
      S_COMPARE:   w_next = ((r_data != PW_ERASED) && (r_pw == r_data)) ? S_GRANTED : S_FAIL;
      S_GRANTED:   w_next = S_GRANTED;
      S_FAIL:      w_next = (r_attempt == ATT_LAST) ? S_LOCKOUT : S_DIG1;
      S_LOCKOUT: begin
`ifdef PW_LOCKOUT_EN
        if (w_lock_done) w_next = S_DIG1;
`endif
      end
      default:     w_next = S_IDLE;
    endcase
    // Session aborts outrank every normal transition.
    if (log_out || (!matchID && (r_state != S_IDLE))) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pw       <= '0;
      r_data     <= '0;
      r_attempt  <= '0;
      r_wait_cnt <= '0;
      r_addr     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pw      <= '0;
          r_data    <= '0;
          r_attempt <= '0;
          r_addr    <= '0;
        end
        S_DIG1:      if (w_take) r_pw[15:12] <= pwdigit;
        S_DIG2:      if (w_take) r_pw[11:8]  <= pwdigit;
        S_DIG3:      if (w_take) r_pw[7:4]   <= pwdigit;
        S_DIG4:      if (w_take) r_pw[3:0]   <= pwdigit;
        // A guest always reads slot 0.
        S_ROM_ADDR:  r_addr <= isGuest ? '0 : {2'b00, intID};
        S_ROM_CATCH: r_data <= q_PW_ROM;
        S_FAIL: begin
          r_pw <= '0;
          if (r_attempt != 3'd7) r_attempt <= r_attempt + 3'd1;
        end
`ifdef PW_LOCKOUT_EN
        S_LOCKOUT:   if (w_lock_done) r_attempt <= '0;
`endif
        default: ;
      endcase
      r_wait_cnt <= ((r_state == S_ROM_WAIT) && (r_wait_cnt != WAIT_LAST)) ? r_wait_cnt + 1'b1 : '0;
    end
  end

  assign addr_PW_ROM   = r_addr;
  assign matchPW       = (r_state == S_GRANTED);
  assign pwFail        = (r_state == S_FAIL);
  assign o_dbg_state   = r_state;
  assign o_dbg_attempt = r_attempt;
endmodule

// File: tb/tb_pw_checking.sv
// Bench for pw_checking: vector table, hand-written corner sequences and randomized sessions
// checked against a session-level password model.
module tb_pw_checking;
  import pw_pkg::*;

  localparam int RW   = 2;
  localparam int MAXA = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pwdigit;
  logic        pwenter, log_out, matchID, isGuest;
  logic [2:0]  intID;
  logic [15:0] q_PW_ROM;
  logic [4:0]  addr_PW_ROM;
  logic        matchPW, pwFail, lockedOut;
  logic [3:0]  dbg_state;
  logic [2:0]  dbg_attempt;

  logic [15:0] rom [0:31];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [2:0]  exp_q[$];

  typedef struct {
    logic [2:0]  id;
    logic        guest;
    logic [15:0] pw;
    logic        exp_match;
  } vec_t;
  vec_t vecs[7];

  // clock / ROM model
  always #5 clk = ~clk;
  assign q_PW_ROM = rom[addr_PW_ROM];

  pw_checking #(
    .MAX_ATTEMPTS (MAXA),
    .ROM_WAIT     (RW)
`ifdef PW_LOCKOUT_EN
    ,.LOCKOUT_CYCLES (10)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pwdigit       (pwdigit),
    .pwenter       (pwenter),
    .log_out       (log_out),
    .matchID       (matchID),
    .isGuest       (isGuest),
    .intID         (intID),
    .q_PW_ROM      (q_PW_ROM),
    .addr_PW_ROM   (addr_PW_ROM),
    .matchPW       (matchPW),
    .pwFail        (pwFail),
    .lockedOut     (lockedOut),
    .o_dbg_state   (dbg_state),
    .o_dbg_attempt (dbg_attempt)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic enter_digit(input logic [3:0] d);
    pwdigit = d;
    pwenter = 1'b1;
    step();
    pwenter = 1'b0;
    pwdigit = 4'($urandom_range(0, 15));
  endtask

  task automatic enter_pw(input logic [15:0] pw, input bit gaps);
    for (int i = 0; i < 4; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      enter_digit(pw[15-4*i -: 4]);
    end
  endtask

  task automatic start_session(input logic [2:0] id, input logic guest);
    log_out = 1'b1;
    step();
    log_out = 1'b0;
    intID   = id;
    isGuest = guest;
    matchID = 1'b1;
    step();
  endtask

  // One full entry: the verdict must appear exactly RW+3 cycles after the 4th pwenter.
  task automatic run_entry(input string name, input logic [15:0] pw, input logic exp_m,
                           input logic exp_l, input bit gaps);
    logic       bad_early;
    logic       got_m, got_f, got_l;
    logic [2:0] exp;
    exp_q.push_back({exp_l, exp_m, ~exp_m});
    enter_pw(pw, gaps);
    bad_early = 1'b0;
    for (int k = 1; k <= RW + 2; k++) begin
      step();
      if (matchPW || pwFail) bad_early = 1'b1;
    end
    check({name, " early"}, 32'(bad_early), 32'd0);
    step();
    got_m = matchPW;
    got_f = pwFail;
    if (!exp_m) begin
      step();
      check({name, " pwFail width"}, 32'(pwFail), 32'd0);
    end
    got_l = lockedOut;
    exp   = exp_q.pop_front();
    check({name, " {lock,match,fail}"}, 32'({got_l, got_m, got_f}), 32'(exp));
  endtask

  initial begin
    logic        bad;
    int          cnt;
    logic [2:0]  id;
    logic [15:0] pw;
    logic        m, l, done;
    int          fails;

    for (int i = 0; i < 32; i++) rom[i] = 16'($urandom);
    rom[0] = 16'hFFFF;
    rom[3] = 16'h1234;
    rom[5] = 16'h0000;
    rom[6] = 16'hABCD;
    rom[7] = 16'hFFFF;

    vecs[0] = '{3'd3, 1'b0, 16'h1234, 1'b1};
    vecs[1] = '{3'd3, 1'b0, 16'h1235, 1'b0};
    vecs[2] = '{3'd0, 1'b1, 16'hFFFF, 1'b0};
    vecs[3] = '{3'd5, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{3'd7, 1'b0, 16'hFFFF, 1'b0};
    vecs[5] = '{3'd6, 1'b0, 16'hABCD, 1'b1};
    vecs[6] = '{3'd6, 1'b0, 16'hABCC, 1'b0};

    // reset
    rst = 1'b0; pwdigit = '0; pwenter = 1'b0; log_out = 1'b0;
    matchID = 1'b0; isGuest = 1'b0; intID = '0;
    #3;
    check("reset outputs", 32'({addr_PW_ROM, matchPW, pwFail, lockedOut}), 32'd0);
    check("reset state", 32'(dbg_state), 32'(S_IDLE));
    idle(3);
    #2 rst = 1'b1;
    step();
    check("idle after reset", 32'({matchPW, pwFail, lockedOut, dbg_attempt}), 32'd0);

    // table-driven first attempts
    for (int i = 0; i < 7; i++) begin
      start_session(vecs[i].id, vecs[i].guest);
      run_entry($sformatf("vec%0d", i), vecs[i].pw, vecs[i].exp_match, 1'b0, 1'b0);
      check($sformatf("vec%0d addr", i), 32'(addr_PW_ROM), 32'({2'b00, vecs[i].id}));
    end

    // wrong then right
    start_session(3'd3, 1'b0);
    run_entry("wr wrong", 16'h1235, 1'b0, 1'b0, 1'b0);
    check("wr attempt", 32'(dbg_attempt), 32'd1);
    check("wr back in DIG1", 32'(dbg_state), 32'(S_DIG1));
    run_entry("wr right", 16'h1234, 1'b1, 1'b0, 1'b1);

    // lockout
    start_session(3'd3, 1'b0);
    run_entry("lock 1", 16'h4321, 1'b0, 1'b0, 1'b0);
    run_entry("lock 2", 16'h0001, 1'b0, 1'b0, 1'b0);
    run_entry("lock 3", 16'h1233, 1'b0, 1'b1, 1'b0);
`ifdef PW_LOCKOUT_EN
    cnt = 1;
    for (int k = 0; k < 40 && lockedOut; k++) begin
      pwdigit = 4'd1;
      pwenter = 1'b1;
      step();
      if (lockedOut) cnt++;
    end
    pwenter = 1'b0;
    check("lockout length", 32'(cnt), 32'd10);
    check("lockout release state", 32'(dbg_state), 32'(S_DIG1));
    check("lockout release attempt", 32'(dbg_attempt), 32'd0);
    run_entry("after lockout", 16'h1234, 1'b1, 1'b0, 1'b0);
`else
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      pwdigit = 4'(k);
      pwenter = 1'b1;
      step();
      if (!lockedOut || dbg_state != S_LOCKOUT) bad = 1'b1;
    end
    pwenter = 1'b0;
    check("lockout held", 32'(bad), 32'd0);
    log_out = 1'b1;
    step();
    log_out = 1'b0;
    check("lockout log_out", 32'({lockedOut, dbg_state}), 32'({1'b0, S_IDLE}));
`endif

    // abort during DIG3, with a dropped pwenter
    start_session(3'd3, 1'b0);
    run_entry("abort pre", 16'h1111, 1'b0, 1'b0, 1'b0);
    enter_digit(4'd1);
    enter_digit(4'd2);
    check("abort in DIG3", 32'(dbg_state), 32'(S_DIG3));
    log_out = 1'b1; pwenter = 1'b1; pwdigit = 4'd9;
    step();
    log_out = 1'b0; pwenter = 1'b0;
    check("abort dig3 idle", 32'({matchPW, dbg_state}), 32'({1'b0, S_IDLE}));
    step();
    check("abort attempt cleared", 32'(dbg_attempt), 32'd0);
    run_entry("abort restart", 16'h1234, 1'b1, 1'b0, 1'b0);

    // abort during ROM_WAIT
    start_session(3'd3, 1'b0);
    enter_pw(16'h1234, 1'b0);
    idle(2);
    check("in ROM_WAIT", 32'(dbg_state), 32'(S_ROM_WAIT));
    log_out = 1'b1;
    step();
    log_out = 1'b0;
    check("abort romwait idle", 32'(dbg_state), 32'(S_IDLE));
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (matchPW || pwFail) bad = 1'b1;
    end
    check("abort romwait no verdict", 32'(bad), 32'd0);

    // async reset mid ROM_WAIT
    start_session(3'd3, 1'b0);
    enter_pw(16'h1234, 1'b0);
    idle(2);
    #2 rst = 1'b0;
    #1;
    check("async reset outputs", 32'({addr_PW_ROM, matchPW, pwFail, lockedOut}), 32'd0);
    check("async reset state", 32'({dbg_state, dbg_attempt}), 32'({S_IDLE, 3'd0}));
    #2 rst = 1'b1;
    step();

    // randomized sessions against the password model
    for (int s = 0; s < 14; s++) begin
      rom[1] = 16'($urandom);
      rom[2] = 16'($urandom);
      rom[4] = 16'($urandom);
      id = 3'($urandom_range(0, 7));
      start_session(id, id == 3'd0);
      fails = 0;
      done  = 1'b0;
      while (!done) begin
        pw = ($urandom_range(0, 1) == 1) ? rom[id] : 16'($urandom);
        m  = (pw == rom[id]) && (rom[id] != 16'hFFFF);
        if (!m) fails++;
        l  = (fails == MAXA);
        run_entry($sformatf("rand s%0d", s), pw, m, l, 1'b1);
        if (m || l) done = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
